// File: rtl/adpcm_adapt_quan.sv
// adpcm_adapt_quan: G.726 adaptive quantizer (LOG, SUBTB, QUAN) as a serial multi-cycle datapath.
// Build option QUAN_EARLY_EXIT_EN: LOG and SRCH stop as soon as the answer is known (same codewords).
//
// state | meaning
// IDLE  | waiting for START; I holds the last codeword
// LOG   | scanning DQM from bit 14 down for the exponent
// SUB   | forming DL = {EXP,MANT} and DLN = DL - Y/4 (mod 4096)
// SRCH  | walking the rate's threshold table, counting IMAG
// OUT   | mapping sign/IMAG to the codeword, pulsing DONE
module adpcm_adapt_quan #(
  parameter int D_WIDTH = 16,
  parameter int Y_WIDTH = 13
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               START,
  input  logic [1:0]         RATE,
  input  logic [D_WIDTH-1:0] D,
  input  logic [Y_WIDTH-1:0] Y,
  output logic               BUSY,
  output logic               DONE,
  output logic [4:0]         I
);

  typedef enum logic [2:0] {S_IDLE, S_LOG, S_SUB, S_SRCH, S_OUT} state_t;

  // Thresholds in signed DLN units; 4095 pads the short tables and is never reached by DLN.
  localparam logic signed [12:0] SENT = 13'sd4095;
  localparam logic signed [12:0] THR_40K [0:14] = '{
    -13'sd122, -13'sd16, 13'sd68, 13'sd139, 13'sd198, 13'sd250, 13'sd298, 13'sd339,
    13'sd378, 13'sd413, 13'sd445, 13'sd475, 13'sd502, 13'sd526, 13'sd548};
  localparam logic signed [12:0] THR_32K [0:14] = '{
    -13'sd124, 13'sd80, 13'sd178, 13'sd246, 13'sd300, 13'sd349, 13'sd400, SENT,
    SENT, SENT, SENT, SENT, SENT, SENT, SENT};
  localparam logic signed [12:0] THR_24K [0:14] = '{
    13'sd8, 13'sd218, 13'sd331, SENT, SENT, SENT, SENT, SENT,
    SENT, SENT, SENT, SENT, SENT, SENT, SENT};
  localparam logic signed [12:0] THR_16K [0:14] = '{
    13'sd261, SENT, SENT, SENT, SENT, SENT, SENT, SENT,
    SENT, SENT, SENT, SENT, SENT, SENT, SENT};

  function automatic logic signed [12:0] thr_lookup(input logic [1:0] rate, input logic [3:0] idx);
    logic signed [12:0] t;
    case (rate)
      2'b00:   t = THR_40K[idx];
      2'b01:   t = THR_32K[idx];
      2'b10:   t = THR_24K[idx];
      default: t = THR_16K[idx];
    endcase
    return t;
  endfunction

  state_t      state;
  logic        ds;
  logic [14:0] dqm;
  logic [12:0] y_q;
  logic [1:0]  rate_q;
  logic [3:0]  cnt;
  logic [3:0]  exp_q;
  logic [11:0] dln;
  logic [3:0]  imag;
`ifndef QUAN_EARLY_EXIT_EN
  logic        found;
`endif

  logic [15:0]        d_neg;
  logic [14:0]        dqm_in;
  logic [6:0]         mant;
  logic [11:0]        dln_next;
  logic signed [12:0] sdln;
  logic signed [12:0] thr;
  logic               thr_le;
  logic [4:0]         mask;
  logic [4:0]         raw;
  logic [4:0]         code;

  always_comb begin
    d_neg = 16'(-D);
    // -32768 has no positive 16-bit counterpart; clamp the magnitude.
    if (!D[15])
      dqm_in = D[14:0];
    else if (d_neg[15])
      dqm_in = 15'h7fff;
    else
      dqm_in = d_neg[14:0];

    mant     = 7'({dqm, 7'b0} >> exp_q);
    dln_next = 12'({1'b0, exp_q, mant}) - 12'(y_q >> 2);

    sdln   = signed'({dln[11], dln});
    thr    = thr_lookup(rate_q, 4'd14 - cnt);
    thr_le = (thr <= sdln);

    case (rate_q)
      2'b00:   mask = 5'h1f;
      2'b01:   mask = 5'h0f;
      2'b10:   mask = 5'h07;
      default: mask = 5'h03;
    endcase
    raw = ds ? (~{1'b0, imag} & mask) : {1'b0, imag};
    // 16k uses all four 2-bit codes; the other rates reserve zero.
    code = (raw == 5'd0 && rate_q != 2'b11) ? mask : raw;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= S_IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      I      <= 5'd0;
      ds     <= 1'b0;
      dqm    <= 15'd0;
      y_q    <= 13'd0;
      rate_q <= 2'b00;
      cnt    <= 4'd0;
      exp_q  <= 4'd0;
      dln    <= 12'd0;
      imag   <= 4'd0;
`ifndef QUAN_EARLY_EXIT_EN
      found  <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            ds     <= D[15];
            dqm    <= dqm_in;
            y_q    <= Y;
            rate_q <= RATE;
            cnt    <= 4'd14;
            exp_q  <= 4'd0;
`ifndef QUAN_EARLY_EXIT_EN
            found  <= 1'b0;
`endif
            BUSY   <= 1'b1;
            state  <= S_LOG;
          end
        end
        S_LOG: begin
`ifdef QUAN_EARLY_EXIT_EN
          if (dqm[cnt] || cnt == 4'd0) begin
            exp_q <= cnt;
            state <= S_SUB;
          end else begin
            cnt <= cnt - 4'd1;
          end
`else
          if (dqm[cnt] && !found) begin
            exp_q <= cnt;
            found <= 1'b1;
          end
          if (cnt == 4'd0)
            state <= S_SUB;
          else
            cnt <= cnt - 4'd1;
`endif
        end
        S_SUB: begin
          dln   <= dln_next;
          cnt   <= 4'd14;
          imag  <= 4'd0;
          state <= S_SRCH;
        end
        S_SRCH: begin
`ifdef QUAN_EARLY_EXIT_EN
          if (!thr_le) begin
            state <= S_OUT;
          end else begin
            imag <= imag + 4'd1;
            if (cnt == 4'd0)
              state <= S_OUT;
            else
              cnt <= cnt - 4'd1;
          end
`else
          if (thr_le)
            imag <= imag + 4'd1;
          if (cnt == 4'd0)
            state <= S_OUT;
          else
            cnt <= cnt - 4'd1;
`endif
        end
        S_OUT: begin
          I     <= code;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adpcm_adapt_quan.sv
// Bench for adpcm_adapt_quan: directed vector table, random samples against a plain-arithmetic
// G.726 quantizer model, and handshake / mid-operation reset sequences.
`timescale 1ns/1ps
module tb_adpcm_adapt_quan;
  logic        CLK = 1'b0;
  logic        reset;
  logic        START;
  logic [1:0]  RATE;
  logic [15:0] D;
  logic [12:0] Y;
  logic        BUSY;
  logic        DONE;
  logic [4:0]  I;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  adpcm_adapt_quan dut (
    .CLK(CLK), .reset(reset), .START(START), .RATE(RATE), .D(D), .Y(Y),
    .BUSY(BUSY), .DONE(DONE), .I(I)
  );

  typedef struct {
    logic [1:0] rate;
    int         d;
    int         y;
    int         exp_i;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Quantizer from first principles: log2 magnitude in 4.7 format, subtract Y/4 as a signed
  // number, count table thresholds not above it, then map sign and count onto the code.
  function automatic int model_i(input logic [1:0] rate, input int d, input int y);
    int mag, e, dl, dln, cnt, nlev;
    int thr[$];
    mag = (d < 0) ? -d : d;
    if (mag > 32767) mag = 32767;
    e = 0;
    for (int b = 0; b < 15; b++)
      if (mag >= (1 << b)) e = b;
    dl  = e * 128 + (((mag << 7) >> e) & 127);
    dln = dl - (y / 4);
    case (rate)
      2'd0:    thr = '{-122, -16, 68, 139, 198, 250, 298, 339, 378, 413, 445, 475, 502, 526, 548};
      2'd1:    thr = '{-124, 80, 178, 246, 300, 349, 400};
      2'd2:    thr = '{8, 218, 331};
      default: thr = '{261};
    endcase
    cnt = 0;
    foreach (thr[k])
      if (thr[k] <= dln) cnt++;
    nlev = 2 * thr.size() + 1;
    if (rate == 2'd3) return (d < 0) ? 3 - cnt : cnt;
    if (d < 0) return nlev - cnt;
    return (cnt == 0) ? nlev : cnt;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_sample(input string tag, input logic [1:0] rate, input int d, input int y,
                            input int exp_i);
    int lat;
    lat = 0;
    while (BUSY && lat < 40) begin
      tick();
      lat++;
    end
    START = 1'b1;
    RATE  = rate;
    D     = 16'(d);
    Y     = 13'(y);
    tick();
    check({tag, "_busy_accept"}, int'(BUSY), 1);
    // Scramble the inputs and poke START while busy; none of it may reach this sample.
    START = 1'b0;
    D     = 16'($urandom);
    Y     = 13'($urandom);
    RATE  = 2'($urandom);
    lat   = 0;
    while (!DONE && lat < 40) begin
      START = (lat == 1) && BUSY;
      tick();
      lat++;
    end
    START = 1'b0;
    check({tag, "_done_seen"}, int'(DONE), 1);
    check({tag, "_busy_at_done"}, int'(BUSY), 0);
    check({tag, "_code"}, int'(I), exp_i);
`ifndef QUAN_EARLY_EXIT_EN
    check({tag, "_latency"}, lat, 32);
`endif
    tick();
    check({tag, "_done_pulse"}, int'(DONE), 0);
    check({tag, "_i_hold"}, int'(I), exp_i);
  endtask

  vec_t vecs[$];

  initial begin
    int rate_r, d_r, y_r, n_done, first, second;

    reset = 1'b1;
    START = 1'b0;
    RATE  = 2'b00;
    D     = 16'd0;
    Y     = 13'd0;
    repeat (3) tick();
    check("reset_busy", int'(BUSY), 0);
    check("reset_done", int'(DONE), 0);
    check("reset_i", int'(I), 0);
    reset = 1'b0;
    tick();

    vecs.push_back(vec_t'{2'b01,    100, 544,  7});
    vecs.push_back(vec_t'{2'b01,   -100, 544,  8});
    vecs.push_back(vec_t'{2'b01,      0, 544, 15});
    vecs.push_back(vec_t'{2'b00, -32768,   0, 16});
    vecs.push_back(vec_t'{2'b10,    100, 544,  3});
    vecs.push_back(vec_t'{2'b10,   -100, 544,  4});
    vecs.push_back(vec_t'{2'b11,    100, 544,  1});
    vecs.push_back(vec_t'{2'b11,   -100, 544,  2});
    vecs.push_back(vec_t'{2'b11,      0, 544,  0});
    vecs.push_back(vec_t'{2'b11,     -1, 544,  3});
    vecs.push_back(vec_t'{2'b00,      0, 544, 31});
    vecs.push_back(vec_t'{2'b00,     -1, 544, 31});
    vecs.push_back(vec_t'{2'b00,      8, 544,  5});
    vecs.push_back(vec_t'{2'b00,      1, 400,  1});
    vecs.push_back(vec_t'{2'b00,     -1, 400, 30});
    vecs.push_back(vec_t'{2'b01,      9,   0,  7});
    vecs.push_back(vec_t'{2'b01,      8,   0,  6});
    vecs.push_back(vec_t'{2'b01,      1, 496,  1});
    vecs.push_back(vec_t'{2'b01,      1, 500, 15});
    vecs.push_back(vec_t'{2'b10,      1,   0,  7});
    vecs.push_back(vec_t'{2'b10,      2,   0,  1});

    foreach (vecs[n])
      run_sample($sformatf("vec%0d", n), vecs[n].rate, vecs[n].d, vecs[n].y, vecs[n].exp_i);

    for (int n = 0; n < 300; n++) begin
      rate_r = int'($urandom_range(0, 3));
      if (n % 50 == 0)
        d_r = -32768;
      else
        d_r = int'($signed(16'($urandom))) >>> $urandom_range(0, 15);
      y_r = (n % 2 == 1) ? int'($urandom_range(544, 5120)) : int'($urandom_range(0, 8191));
      run_sample($sformatf("rand%0d", n), 2'(rate_r), d_r, y_r, model_i(2'(rate_r), d_r, y_r));
    end

    // Reset while the threshold search is running: abort, no DONE, clean restart.
    run_sample("pre_reset", 2'b01, 100, 544, 7);
    START = 1'b1;
    RATE  = 2'b01;
    D     = 16'd100;
    Y     = 13'd544;
    tick();
    START = 1'b0;
    repeat (17) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", int'(BUSY), 0);
    check("midrst_done", int'(DONE), 0);
    check("midrst_i", int'(I), 0);
    n_done = 0;
    repeat (40) begin
      tick();
      if (DONE) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    run_sample("post_reset", 2'b01, -100, 544, 8);

    // START held high: the second sample is accepted on the cycle after the first DONE.
    START  = 1'b1;
    RATE   = 2'b01;
    D      = 16'd100;
    Y      = 13'd544;
    first  = -1;
    second = -1;
    tick();
    for (int c = 1; c <= 100 && second < 0; c++) begin
      tick();
      if (DONE) begin
        check("b2b_code", int'(I), 7);
        if (first < 0) first = c;
        else second = c;
      end
    end
    START = 1'b0;
    check("b2b_first_seen", int'(first > 0), 1);
    check("b2b_second_gap", second, 2 * first + 1);
`ifndef QUAN_EARLY_EXIT_EN
    check("b2b_latency", first, 32);
`endif
    tick();
    check("b2b_done_low", int'(DONE), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
